// File: rtl/adc_pkg.sv
// Shared types and sizing for the ADC channel scanner.
// Channel count and result width follow the ADC128S (8 channels, 12 bits).
package adc_pkg;

  localparam int NUM_CH = 8;
  localparam int RES_W  = 12;
  localparam int CH_W   = $clog2(NUM_CH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    NEXT  = 2'd3
  } adc_state_t;

  typedef logic [RES_W-1:0] adc_sample_t;

endpackage

// File: rtl/adc_next_ch.sv
// Combinational priority finder: lowest set mask bit above (or, with i_incl,
// at or above) the current channel index, plus a found flag.
module adc_next_ch
  import adc_pkg::*;
(
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_cur,
  input  logic              i_incl,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_found
);

  // Descending scan so the last match written is the lowest qualifying bit.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i] && ((CH_W'(i) > i_cur) || (i_incl && (CH_W'(i) == i_cur)))) begin
        o_idx   = CH_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// Autonomous ADC channel scanner: on each period tick, converts every enabled
// channel in ascending order, stores results per channel and streams them out.
// Define ADC_AVG_EN to store a rounded 2-tap average instead of the raw result.
module adc_scan_ctrl
  import adc_pkg::*;
#(
  parameter int PERIOD = 2500
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              start_cnv,
  output logic [CH_W-1:0]   channel,
  input  logic [RES_W-1:0]  result,
  input  logic              cnv_complete,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [RES_W-1:0]  rd_data,
  output logic              smp_valid,
  output logic [CH_W-1:0]   smp_ch,
  output logic [RES_W-1:0]  smp_data,
  output logic              scan_done,
  output logic              overrun
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  adc_state_t          r_state;
  adc_state_t          w_nextState;
  logic [CNT_W-1:0]    r_cnt;
  logic                w_tick;
  logic [NUM_CH-1:0]   r_scanMask;
  logic [CH_W-1:0]     r_idx;
  adc_sample_t         r_bank [NUM_CH];
  logic                r_smpValid;
  logic [CH_W-1:0]     r_smpCh;
  adc_sample_t         r_smpData;
  logic                r_scanDone;
  logic                r_overrun;
  logic                w_startCnv;
  adc_sample_t         w_wrData;
  logic [NUM_CH-1:0]   w_findMask;
  logic [CH_W-1:0]     w_findCur;
  logic                w_findIncl;
  logic [CH_W-1:0]     w_findIdx;
  logic                w_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(PERIOD - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_tick = en && (r_cnt == CNT_W'(PERIOD - 1));

  // In IDLE the finder picks the first channel of the live mask; during a
  // scan it walks the frozen copy strictly above the current channel.
  assign w_findMask = (r_state == IDLE) ? ch_mask : r_scanMask;
  assign w_findCur  = (r_state == IDLE) ? '0 : r_idx;
  assign w_findIncl = (r_state == IDLE);

  adc_next_ch u_nextCh (
    .i_mask  (w_findMask),
    .i_cur   (w_findCur),
    .i_incl  (w_findIncl),
    .o_idx   (w_findIdx),
    .o_found (w_found)
  );

`ifdef ADC_AVG_EN
  logic [RES_W:0] w_sum;
  assign w_sum    = {1'b0, r_bank[r_idx]} + {1'b0, result} + {{RES_W{1'b0}}, 1'b1};
  assign w_wrData = w_sum[RES_W:1];
`else
  assign w_wrData = result;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_startCnv  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick && (ch_mask != '0)) begin
          w_nextState = ISSUE;
        end
      end
      ISSUE: begin
        w_startCnv  = 1'b1;
        w_nextState = BUSY;
      end
      BUSY: begin
        if (cnv_complete) begin
          w_nextState = NEXT;
        end
      end
      NEXT: begin
        w_nextState = (w_found && en) ? ISSUE : IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // scan_done is suppressed when en has dropped, so an aborted scan never
  // looks complete to the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scanMask <= '0;
      r_idx      <= '0;
      r_smpValid <= 1'b0;
      r_smpCh    <= '0;
      r_smpData  <= '0;
      r_scanDone <= 1'b0;
      r_overrun  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_bank[i] <= '0;
      end
    end else begin
      r_smpValid <= 1'b0;
      r_scanDone <= 1'b0;
      if (w_tick && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_tick && (ch_mask != '0)) begin
            r_scanMask <= ch_mask;
            r_idx      <= w_findIdx;
          end
        end
        BUSY: begin
          if (cnv_complete) begin
            r_bank[r_idx] <= w_wrData;
            r_smpValid    <= 1'b1;
            r_smpCh       <= r_idx;
            r_smpData     <= w_wrData;
          end
        end
        NEXT: begin
          if (w_found && en) begin
            r_idx <= w_findIdx;
          end else if (!w_found && en) begin
            r_scanDone <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign start_cnv = w_startCnv;
  assign channel   = r_idx;
  assign rd_data   = r_bank[rd_ch];
  assign smp_valid = r_smpValid;
  assign smp_ch    = r_smpCh;
  assign smp_data  = r_smpData;
  assign scan_done = r_scanDone;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl with a fixed-latency ADC model.
// Expected stored values follow ADC_AVG_EN when the macro is defined.
module tb_adc_scan_ctrl;
  import adc_pkg::*;

  localparam int PERIOD = 50;
  localparam int LAT    = 6;
`ifdef ADC_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic              start_cnv;
  logic [CH_W-1:0]   channel;
  logic [RES_W-1:0]  result = '0;
  logic              cnv_complete = 1'b0;
  logic [CH_W-1:0]   rd_ch = '0;
  logic [RES_W-1:0]  rd_data;
  logic              smp_valid;
  logic [CH_W-1:0]   smp_ch;
  logic [RES_W-1:0]  smp_data;
  logic              scan_done;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  logic [RES_W-1:0] adcTable [NUM_CH];
  logic [RES_W-1:0] expBank  [NUM_CH];

  int              startCount = 0;
  int              smpCount = 0;
  int              doneCount = 0;
  logic [CH_W-1:0] startLog   [256];
  logic [CH_W-1:0] smpChLog   [256];
  logic [11:0]     smpDataLog [256];

  adc_scan_ctrl #(.PERIOD(PERIOD)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .ch_mask      (ch_mask),
    .start_cnv    (start_cnv),
    .channel      (channel),
    .result       (result),
    .cnv_complete (cnv_complete),
    .rd_ch        (rd_ch),
    .rd_data      (rd_data),
    .smp_valid    (smp_valid),
    .smp_ch       (smp_ch),
    .smp_data     (smp_data),
    .scan_done    (scan_done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  // ADC model: answers every start_cnv after LAT cycles, even across a reset,
  // so a stale completion reaches the DUT.
  initial begin
    logic [CH_W-1:0] ch;
    forever begin
      @(negedge clk);
      if (start_cnv === 1'b1) begin
        ch = channel;
        repeat (LAT) @(negedge clk);
        result       = adcTable[ch];
        cnv_complete = 1'b1;
        @(negedge clk);
        cnv_complete = 1'b0;
        result       = '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (start_cnv === 1'b1 && startCount < 256) begin
        startLog[startCount] = channel;
        startCount++;
      end
      if (smp_valid === 1'b1 && smpCount < 256) begin
        smpChLog[smpCount]   = smp_ch;
        smpDataLog[smpCount] = smp_data;
        smpCount++;
      end
      if (scan_done === 1'b1) begin
        doneCount++;
      end
    end
  end

  function automatic logic [11:0] expStore(input logic [11:0] old, input logic [11:0] res);
    logic [12:0] s;
    s = {1'b0, old} + {1'b0, res} + 13'd1;
    return AVG ? s[12:1] : res;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tickClk();
    @(negedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic e, input logic [NUM_CH-1:0] m);
    tickClk();
    en      = e;
    ch_mask = m;
  endtask

  task automatic readBank(input string tag, input int ch, input logic [11:0] expected);
    rd_ch = CH_W'(ch);
    #1;
    checkOutput(tag, rd_data, expected);
  endtask

  task automatic waitDone(input int base, input int budget, input string tag);
    int n = 0;
    while (doneCount <= base && n < budget) begin
      tickClk();
      n++;
    end
    checkOutput(tag, doneCount > base, 1);
  endtask

  task automatic waitStart(input int target, input int budget, input string tag);
    int n = 0;
    while (startCount < target && n < budget) begin
      tickClk();
      n++;
    end
    checkOutput(tag, startCount >= target, 1);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_start_cnv"}, start_cnv, 0);
    checkOutput({tag, "_channel"},   channel, 0);
    checkOutput({tag, "_smp_valid"}, smp_valid, 0);
    checkOutput({tag, "_smp_ch"},    smp_ch, 0);
    checkOutput({tag, "_smp_data"},  smp_data, 0);
    checkOutput({tag, "_scan_done"}, scan_done, 0);
    checkOutput({tag, "_overrun"},   overrun, 0);
    for (int i = 0; i < NUM_CH; i++) begin
      readBank($sformatf("%s_bank%0d", tag, i), i, 12'h000);
    end
  endtask

  initial begin
    int sS, sM, sD;
    logic [11:0] want;

    adcTable[0] = 12'h123; adcTable[1] = 12'h111;
    adcTable[2] = 12'hABC; adcTable[3] = 12'h333;
    adcTable[4] = 12'h444; adcTable[5] = 12'h555;
    adcTable[6] = 12'h666; adcTable[7] = 12'h777;
    for (int i = 0; i < NUM_CH; i++) expBank[i] = '0;

    repeat (3) tickClk();
    checkCleared("reset");
    tickClk();
    rst = 1'b0;

    // Basic scan of channels 0 and 2
    sS = startCount; sM = smpCount; sD = doneCount;
    applyStimulus(1'b1, 8'h05);
    waitDone(sD, 200, "t1_done_seen");
    repeat (2) tickClk();
    applyStimulus(1'b0, 8'h05);
    checkOutput("t1_starts", startCount - sS, 2);
    checkOutput("t1_first_ch", startLog[sS], 0);
    checkOutput("t1_second_ch", startLog[sS + 1], 2);
    checkOutput("t1_samples", smpCount - sM, 2);
    checkOutput("t1_smp0_ch", smpChLog[sM], 0);
    checkOutput("t1_smp0_data", smpDataLog[sM], AVG ? 12'h092 : 12'h123);
    checkOutput("t1_smp1_ch", smpChLog[sM + 1], 2);
    checkOutput("t1_smp1_data", smpDataLog[sM + 1], AVG ? 12'h55E : 12'hABC);
    checkOutput("t1_done_count", doneCount - sD, 1);
    checkOutput("t1_overrun", overrun, 0);
    expBank[0] = expStore(expBank[0], adcTable[0]);
    expBank[2] = expStore(expBank[2], adcTable[2]);
    readBank("t1_rd0", 0, expBank[0]);
    readBank("t1_rd1", 1, 12'h000);
    readBank("t1_rd2", 2, expBank[2]);

    // Empty mask: ticks are ignored
    sS = startCount; sM = smpCount; sD = doneCount;
    applyStimulus(1'b1, 8'h00);
    repeat (1000) tickClk();
    applyStimulus(1'b0, 8'h00);
    checkOutput("t2_starts", startCount - sS, 0);
    checkOutput("t2_samples", smpCount - sM, 0);
    checkOutput("t2_done", doneCount - sD, 0);
    checkOutput("t2_overrun", overrun, 0);

    // Mask change mid-scan only applies on the next tick
    sS = startCount; sD = doneCount;
    applyStimulus(1'b1, 8'h01);
    waitStart(sS + 1, 100, "t3_first_start");
    ch_mask = 8'h80;
    waitDone(sD, 100, "t3_done1_seen");
    checkOutput("t3_scan1_starts", startCount - sS, 1);
    checkOutput("t3_scan1_ch", startLog[sS], 0);
    sD = doneCount;
    waitDone(sD, 100, "t3_done2_seen");
    repeat (2) tickClk();
    applyStimulus(1'b0, 8'h80);
    checkOutput("t3_total_starts", startCount - sS, 2);
    checkOutput("t3_scan2_ch", startLog[sS + 1], 7);
    checkOutput("t3_overrun", overrun, 0);
    expBank[0] = expStore(expBank[0], adcTable[0]);
    expBank[7] = expStore(expBank[7], adcTable[7]);
    readBank("t3_rd0", 0, expBank[0]);
    readBank("t3_rd7", 7, expBank[7]);

    // en dropped while channel 3 is in flight
    sS = startCount; sM = smpCount; sD = doneCount;
    applyStimulus(1'b1, 8'h0F);
    waitStart(sS + 4, 200, "t4_ch3_start");
    en = 1'b0;
    repeat (20) tickClk();
    checkOutput("t4_starts", startCount - sS, 4);
    checkOutput("t4_last_ch", startLog[sS + 3], 3);
    checkOutput("t4_samples", smpCount - sM, 4);
    checkOutput("t4_last_smp_ch", smpChLog[sM + 3], 3);
    checkOutput("t4_no_done", doneCount - sD, 0);
    for (int i = 0; i < 4; i++) expBank[i] = expStore(expBank[i], adcTable[i]);
    readBank("t4_rd3", 3, expBank[3]);
    readBank("t4_rd1", 1, expBank[1]);
    sS = startCount; sD = doneCount;
    applyStimulus(1'b1, 8'h02);
    waitDone(sD, 150, "t4_restart_done");
    applyStimulus(1'b0, 8'h02);
    checkOutput("t4_restart_starts", startCount - sS, 1);
    checkOutput("t4_restart_ch", startLog[sS], 1);
    expBank[1] = expStore(expBank[1], adcTable[1]);

    // Scan longer than the period raises sticky overrun
    sS = startCount; sM = smpCount; sD = doneCount;
    applyStimulus(1'b1, 8'hFF);
    waitDone(sD, 300, "t5_done_seen");
    applyStimulus(1'b0, 8'hFF);
    checkOutput("t5_overrun", overrun, 1);
    checkOutput("t5_starts", startCount - sS, 8);
    checkOutput("t5_samples", smpCount - sM, 8);
    for (int i = 0; i < NUM_CH; i++) begin
      want = expStore(expBank[i], adcTable[i]);
      expBank[i] = want;
      checkOutput($sformatf("t5_order%0d", i), startLog[sS + i], i);
      checkOutput($sformatf("t5_smp_data%0d", i), smpDataLog[sM + i], want);
    end
    repeat (5) tickClk();
    checkOutput("t5_overrun_sticky", overrun, 1);

    // Reset while a conversion is in flight
    sS = startCount;
    applyStimulus(1'b1, 8'h01);
    waitStart(sS + 1, 100, "t6_start");
    tickClk();
    tickClk();
    en  = 1'b0;
    rst = 1'b1;
    #1;
    checkCleared("t6_async");
    tickClk();
    rst = 1'b0;
    for (int i = 0; i < NUM_CH; i++) expBank[i] = '0;
    sS = startCount; sM = smpCount;
    repeat (15) tickClk();
    checkOutput("t6_late_smp", smpCount - sM, 0);
    checkOutput("t6_late_start", startCount - sS, 0);
    checkOutput("t6_overrun", overrun, 0);
    readBank("t6_rd0", 0, 12'h000);

    // Two writes to channel 1: averaging gives 0x100 then 0x181
    sD = doneCount;
    adcTable[1] = 12'h1FF;
    applyStimulus(1'b1, 8'h02);
    waitDone(sD, 100, "t7_done1");
    readBank("t7_rd1_first", 1, AVG ? 12'h100 : 12'h1FF);
    adcTable[1] = 12'h201;
    sD = doneCount;
    waitDone(sD, 100, "t7_done2");
    applyStimulus(1'b0, 8'h02);
    readBank("t7_rd1_second", 1, AVG ? 12'h181 : 12'h201);
    checkOutput("t7_smp_data", smpDataLog[smpCount - 1], AVG ? 12'h181 : 12'h201);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
Autonomous channel scanner that sequences the SPI ADC master (spi_master + ADC128S). On each sample-period tick it walks the enabled channels in ascending order. For each channel it issues a one-cycle start_cnv and waits for cnv_complete. It then stores the 12-bit result in a per-channel register bank and emits it on a sample stream. It sits between the ADC SPI master and the audio/effects datapath, which reads the latest per-channel values.

Parameters:
NUM_CH, 8, number of ADC channels scanned (ADC128S has 8); channel index width = $clog2(NUM_CH)
RES_W, 12, ADC result width
PERIOD, 2500, clk cycles between scan start ticks (sample rate = f_clk/PERIOD); must exceed worst-case scan time

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
en  input  1  scanning enable
ch_mask  input  NUM_CH  channel enable bits, bit i = channel i
start_cnv  output  1  one-cycle conversion request to spi_master
channel  output  3  channel select to spi_master, held stable from start_cnv until cnv_complete
result  input  RES_W  conversion result from spi_master, valid when cnv_complete=1
cnv_complete  input  1  conversion-done pulse from spi_master
rd_ch  input  3  read-port channel index
rd_data  output  RES_W  combinational read of stored value for rd_ch
smp_valid  output  1  one-cycle pulse: new sample on smp_ch/smp_data
smp_ch  output  3  channel of emitted sample
smp_data  output  RES_W  emitted sample value
scan_done  output  1  one-cycle pulse after last enabled channel of a scan is stored
overrun  output  1  sticky: tick arrived while a scan was in progress; cleared only by rst

Behaviour:
- Reset values: start_cnv=0, channel=0, smp_valid=0, smp_ch=0, smp_data=0, scan_done=0, overrun=0, all stored values=0, period counter=0, state=IDLE.
- Period counter: counts 0..PERIOD-1 while en=1 and wraps. tick=1 on the cycle the count equals PERIOD-1. Counter is held at 0 while en=0.
- FSM states: IDLE, ISSUE, BUSY, NEXT.
- IDLE: on tick with (ch_mask != 0), latch ch_mask into scan_mask, select the lowest set bit, go to ISSUE. On tick with ch_mask == 0, the tick is ignored and no conversion is issued.
- ISSUE: start_cnv=1 for exactly one cycle with channel = current index, then BUSY. Latency is tick -> start_cnv = 1 cycle.
- BUSY: wait for cnv_complete. On cnv_complete, write result to the bank[channel] and go to NEXT. On the next cycle, smp_valid=1 with smp_ch=channel and smp_data=the stored value.
- NEXT: find the next set bit in scan_mask above the current index. If one is found and en=1, go to ISSUE. Otherwise pulse scan_done and go to IDLE.
- scan_mask is frozen for the whole scan; ch_mask changes take effect at the next tick.
- en deasserted mid-scan: the in-flight conversion completes and is stored, then the FSM returns to IDLE without scan_done.
- Tick while not IDLE: set overrun, drop the tick, and leave the scan undisturbed.
- cnv_complete outside BUSY: ignored.
- Back-to-back: with a single enabled channel, one conversion per tick.
- rd_data reflects a write on the cycle after the write.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. The in-flight SPI transfer result is discarded.

Optional Feature:
ADC_AVG_EN — when defined, each bank write stores (old + result + 1) >> 1, a rounded 2-tap IIR for pot de-noising. The sum is computed at RES_W+1 bits with no overflow. smp_data carries the averaged value. When undefined, the raw result is stored and emitted.

Decomposition:
- Shared package adc_pkg: RES_W, NUM_CH, CH_W localparams; the FSM state enum (IDLE/ISSUE/BUSY/NEXT); typedef adc_sample_t (logic [RES_W-1:0]).
- One natural sub-module: adc_next_ch, a combinational priority finder that returns the next set mask bit above the current index, plus a found flag.
- Register bank and period timer stay inline.

Test Plan:
- PERIOD=200, ch_mask=8'h05, ADC model returns 12'h123 on ch0 and 12'hABC on ch2 -> start_cnv once per channel, channel 0 then 2, smp_valid twice, rd_data(0)=12'h123, rd_data(2)=12'hABC, one scan_done, overrun=0.
- ch_mask=8'h00, en=1 for 1000 cycles -> no start_cnv, no smp_valid, no scan_done.
- PERIOD=50 with ch_mask=8'hFF, scan exceeds period -> overrun=1 and stays 1; the scan in progress completes all 8 channels in order 0..7.
- ch_mask switched 8'h01 -> 8'h80 mid-scan -> the current scan still converts only ch0; the next tick converts only ch7.
- en dropped during BUSY on ch3 of 8'h0F -> ch3 stored, no start_cnv for ch4+, no scan_done, FSM in IDLE.
- rst asserted during BUSY -> outputs and bank = 0 immediately; the late cnv_complete after rst release is ignored. With ADC_AVG_EN, old=12'h100 and result=12'h201 -> stored 12'h181.
